usb_setup_capture: RTL and testbench

- Endpoint-0 SETUP transaction receiver, directly downstream of usb_handshake_multiplexer.
- Consumes the token strobe and the OUT-data byte stream, matches a SETUP token addressed to this device on EP0, and collects the following DATA0 packet of 8 payload bytes plus 2 CRC16 bytes.
- Checks the CRC16 and presents the decoded request fields to the control-transfer handler, with a one-cycle valid pulse or an error pulse.

---
 rtl/usb_pkg.sv | 32 +++
 rtl/usb_setup_capture_if.sv | 37 +++
 rtl/usb_crc16_byte.sv | 21 ++
 rtl/usb_setup_capture.sv | 176 +++++++++++++++++
 tb/tb_usb_setup_capture.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_pkg.sv
// Shared constants and types for the USB endpoint-0 receive path.
package usb_pkg;

    localparam logic [7:0] PID_SETUP = 8'h2D;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;

    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY     = 16'hA001;
    localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

    // 8 request bytes followed by the two CRC16 bytes
    localparam logic [3:0] SETUP_PKT_BYTES = 4'd10;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_PID     = 3'd1,
        ERR_LENGTH  = 3'd2,
        ERR_CRC     = 3'd3,
        ERR_FAIL    = 3'd4,
        ERR_TIMEOUT = 3'd5,
        ERR_PREEMPT = 3'd6
    } err_code_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_RECV,
        ST_CHECK
    } state_t;

endpackage

// File: rtl/usb_setup_capture_if.sv
// Token/OUT-data stream from the handshake multiplexer plus the decoded SETUP request.
interface usb_setup_capture_if;

    logic [6:0]  dev_addr;
    logic [23:0] token_0;
    logic        token_0_strb;
    logic [7:0]  data_o_0;
    logic        data_o_strb_0;
    logic        data_o_end_0;
    logic        data_o_fail_0;
    logic [7:0]  pid_o;

    logic        setup_valid;
    logic [7:0]  bm_request_type;
    logic [7:0]  b_request;
    logic [15:0] w_value;
    logic [15:0] w_index;
    logic [15:0] w_length;
    logic        setup_err;
    logic [2:0]  setup_err_code;
    logic        busy;

    modport master (
        output dev_addr, token_0, token_0_strb, data_o_0, data_o_strb_0,
               data_o_end_0, data_o_fail_0, pid_o,
        input  setup_valid, bm_request_type, b_request, w_value, w_index,
               w_length, setup_err, setup_err_code, busy
    );

    modport slave (
        input  dev_addr, token_0, token_0_strb, data_o_0, data_o_strb_0,
               data_o_end_0, data_o_fail_0, pid_o,
        output setup_valid, bm_request_type, b_request, w_value, w_index,
               w_length, setup_err, setup_err_code, busy
    );

endinterface

// File: rtl/usb_crc16_byte.sv
// Byte-serial USB CRC16 step (reflected polynomial), shared by the OUT check and IN generation.
module usb_crc16_byte
    import usb_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        // NOTE: blocking assignments let the eight shift steps chain within one evaluation.
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/usb_setup_capture.sv
// Endpoint-0 SETUP receiver: matches the SETUP token, collects the DATA0 packet,
// checks CRC16 and presents the request fields with a valid or error pulse.
module usb_setup_capture
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter bit CHECK_CRC      = 1'b1
) (
    input logic          USB_CLKIN,
    input logic          NRST,
    usb_setup_capture_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t          state, state_nxt;
    logic [3:0]      count, count_nxt;
    logic [15:0]     crc, crc_nxt, crc_byte;
    logic [TW-1:0]   tcount, tcount_nxt;
    logic [7:0]      buffer [8];
    logic            match, restart, accept, in_packet;
    logic            valid_nxt, err_nxt;
    err_code_t       code_nxt;

    // Token CRC5 is the multiplexer's responsibility and is not rechecked here.
    logic unused_crc5;
    assign unused_crc5 = &{1'b0, bus.token_0[23:19]};

    assign match = bus.token_0_strb
                && (bus.token_0[7:0]   == PID_SETUP)
                && (bus.token_0[14:8]  == bus.dev_addr)
                && (bus.token_0[18:15] == 4'd0);

    usb_crc16_byte u_crc (
        .crc_in  (crc),
        .data    (bus.data_o_0),
        .crc_out (crc_byte)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        state_nxt  = state;
        count_nxt  = count;
        crc_nxt    = crc;
        tcount_nxt = tcount;
        restart    = 1'b0;
        accept     = 1'b0;
        in_packet  = 1'b0;
        valid_nxt  = 1'b0;
        err_nxt    = 1'b0;
        code_nxt   = ERR_NONE;

        unique case (state)
            ST_IDLE: restart = match;
            ST_WAIT_DATA: begin
                if (match) begin
                    restart  = 1'b1;
                    err_nxt  = 1'b1;
                    code_nxt = ERR_PREEMPT;
                end else if (bus.data_o_strb_0) begin
                    if (bus.pid_o != PID_DATA0) begin
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_PID;
                        state_nxt = ST_IDLE;
                    end else begin
                        accept    = 1'b1;
                        in_packet = 1'b1;
                        state_nxt = ST_RECV;
                    end
                end else if (tcount == T_LAST) begin
                    err_nxt   = 1'b1;
                    code_nxt  = ERR_TIMEOUT;
                    state_nxt = ST_IDLE;
                end else begin
                    tcount_nxt = tcount + TW'(1);
                end
            end
            ST_RECV: begin
                if (match) begin
                    restart  = 1'b1;
                    err_nxt  = 1'b1;
                    code_nxt = ERR_PREEMPT;
                end else begin
                    accept    = bus.data_o_strb_0;
                    in_packet = 1'b1;
                end
            end
            ST_CHECK: begin
                if (count != SETUP_PKT_BYTES) begin
                    err_nxt  = 1'b1;
                    code_nxt = ERR_LENGTH;
                end else if (CHECK_CRC && (crc != CRC16_RESIDUAL)) begin
                    err_nxt  = 1'b1;
                    code_nxt = ERR_CRC;
                end else begin
                    valid_nxt = 1'b1;
                end
                state_nxt = ST_IDLE;
                restart   = match;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // A byte arriving with end is counted before end moves us to CHECK; fail beats end.
        if (accept) begin
            crc_nxt   = crc_byte;
            count_nxt = (count == 4'hF) ? count : count + 4'd1;
        end
        if (in_packet) begin
            if (bus.data_o_fail_0) begin
                err_nxt   = 1'b1;
                code_nxt  = ERR_FAIL;
                state_nxt = ST_IDLE;
            end else if (bus.data_o_end_0) begin
                state_nxt = ST_CHECK;
            end
        end
        if (restart) begin
            state_nxt  = ST_WAIT_DATA;
            count_nxt  = 4'd0;
            crc_nxt    = CRC16_INIT;
            tcount_nxt = '0;
        end
    end

    always_ff @(posedge USB_CLKIN or negedge NRST) begin
        if (!NRST) begin
            state  <= ST_IDLE;
            count  <= 4'd0;
            crc    <= CRC16_INIT;
            tcount <= '0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            crc    <= crc_nxt;
            tcount <= tcount_nxt;
        end
    end

    // NOTE: the byte buffer is not reset; it is only read after 10 fresh bytes have been stored.
    always_ff @(posedge USB_CLKIN) begin
        if (accept && !count[3]) begin
            buffer[count[2:0]] <= bus.data_o_0;
        end
    end

    always_ff @(posedge USB_CLKIN or negedge NRST) begin
        if (!NRST) begin
            bus.setup_valid     <= 1'b0;
            bus.setup_err       <= 1'b0;
            bus.setup_err_code  <= ERR_NONE;
            bus.bm_request_type <= 8'h00;
            bus.b_request       <= 8'h00;
            bus.w_value         <= 16'h0000;
            bus.w_index         <= 16'h0000;
            bus.w_length        <= 16'h0000;
        end else begin
            bus.setup_valid <= valid_nxt;
            bus.setup_err   <= err_nxt;
            if (err_nxt) begin
                bus.setup_err_code <= code_nxt;
            end
            if (valid_nxt) begin
                bus.bm_request_type <= buffer[0];
                bus.b_request       <= buffer[1];
                bus.w_value         <= {buffer[3], buffer[2]};
                bus.w_index         <= {buffer[5], buffer[4]};
                bus.w_length        <= {buffer[7], buffer[6]};
            end
        end
    end

    assign bus.busy = (state != ST_IDLE);

endmodule

// File: tb/tb_usb_setup_capture.sv
// Bench for usb_setup_capture: a CRC-checking and a CRC-skipping instance share one stimulus
// stream; outcomes are predicted per packet by a reference model written from the USB rules.
module tb_usb_setup_capture;

    localparam int TIMEOUT = 1024;
    localparam int TERM_END = 0, TERM_END_LAST = 1, TERM_FAIL = 2, TERM_FAIL_END = 3, TERM_NONE = 4;
    localparam int OUT_VALID = 7;

    logic        usb_clkin = 1'b0;
    logic        nrst;
    logic [6:0]  dev_addr;
    logic [23:0] token_0;
    logic        token_0_strb, data_o_strb_0, data_o_end_0, data_o_fail_0;
    logic [7:0]  data_o_0, pid_o;

    int n_checks = 0;
    int n_errors = 0;
    bit both_high = 1'b0;

    int          lat_a, lat_b, out_a, out_b;
    logic [63:0] fld_a, fld_b, exp_f_a, exp_f_b;

    usb_setup_capture_if bus_a ();
    usb_setup_capture_if bus_b ();

    assign bus_a.dev_addr = dev_addr;           assign bus_b.dev_addr = dev_addr;
    assign bus_a.token_0 = token_0;             assign bus_b.token_0 = token_0;
    assign bus_a.token_0_strb = token_0_strb;   assign bus_b.token_0_strb = token_0_strb;
    assign bus_a.data_o_0 = data_o_0;           assign bus_b.data_o_0 = data_o_0;
    assign bus_a.data_o_strb_0 = data_o_strb_0; assign bus_b.data_o_strb_0 = data_o_strb_0;
    assign bus_a.data_o_end_0 = data_o_end_0;   assign bus_b.data_o_end_0 = data_o_end_0;
    assign bus_a.data_o_fail_0 = data_o_fail_0; assign bus_b.data_o_fail_0 = data_o_fail_0;
    assign bus_a.pid_o = pid_o;                 assign bus_b.pid_o = pid_o;

    usb_setup_capture #(.TIMEOUT_CYCLES(TIMEOUT), .CHECK_CRC(1'b1)) dut_a (
        .USB_CLKIN (usb_clkin), .NRST (nrst), .bus (bus_a));
    usb_setup_capture #(.TIMEOUT_CYCLES(TIMEOUT), .CHECK_CRC(1'b0)) dut_b (
        .USB_CLKIN (usb_clkin), .NRST (nrst), .bus (bus_b));

    always #5 usb_clkin = ~usb_clkin;

    always @(negedge usb_clkin) begin
        if ((bus_a.setup_valid && bus_a.setup_err) || (bus_b.setup_valid && bus_b.setup_err))
            both_high = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] crc_bits(input logic [7:0] pkt[$]);
        logic [15:0] r;
        logic        fb;
        r = 16'hFFFF;
        foreach (pkt[i]) begin
            for (int j = 0; j < 8; j++) begin
                fb = r[0] ^ pkt[i][j];
                r  = r >> 1;
                if (fb) r = r ^ 16'hA001;
            end
        end
        return r;
    endfunction

    function automatic int predict(input logic [7:0] pkt[$], input logic [7:0] pid,
                                   input bit failed, input bit crc_on);
        if (pid != 8'hC3) return 1;
        if (failed) return 4;
        if (pkt.size() != 10) return 2;
        if (crc_on && crc_bits(pkt) != 16'hB001) return 3;
        return OUT_VALID;
    endfunction

    function automatic logic [63:0] pkt_fields(input logic [7:0] pkt[$]);
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) f[8*i +: 8] = pkt[i];
        return f;
    endfunction

    function automatic int exp_latency(input int outcome);
        return (outcome == 1 || outcome == 4 || outcome == 6) ? 0 : 1;
    endfunction

    task automatic build_good(output logic [7:0] pkt[$]);
        logic [15:0] tx;
        pkt = {};
        for (int i = 0; i < 8; i++) pkt.push_back(8'($urandom));
        tx = ~crc_bits(pkt);
        pkt.push_back(tx[7:0]);
        pkt.push_back(tx[15:8]);
    endtask

    // ---------------- drivers / observer ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge usb_clkin);
    endtask

    task automatic send_token(input logic [6:0] addr, input logic [3:0] ep, input logic [7:0] pid);
        token_0 = {5'($urandom), ep, addr, pid};
        token_0_strb = 1'b1;
        @(negedge usb_clkin);
        token_0_strb = 1'b0;
        token_0 = 24'($urandom);
    endtask

    task automatic send_packet(input logic [7:0] pkt[$], input logic [7:0] pid, input int term);
        pid_o = pid;
        foreach (pkt[i]) begin
            repeat ($urandom_range(2, 0)) @(negedge usb_clkin);
            data_o_0 = pkt[i];
            data_o_strb_0 = 1'b1;
            if (term == TERM_END_LAST && i == pkt.size() - 1) data_o_end_0 = 1'b1;
            @(negedge usb_clkin);
            data_o_strb_0 = 1'b0;
            data_o_end_0 = 1'b0;
            data_o_0 = 8'($urandom);
        end
        if (term == TERM_END || term == TERM_FAIL || term == TERM_FAIL_END) begin
            data_o_end_0  = (term != TERM_FAIL);
            data_o_fail_0 = (term != TERM_END);
            @(negedge usb_clkin);
            data_o_end_0  = 1'b0;
            data_o_fail_0 = 1'b0;
        end
    endtask

    // lat = negedges waited after the driving task returned (0 = already visible)
    task automatic wait_outcome(input int limit);
        lat_a = -1; lat_b = -1; out_a = 0; out_b = 0;
        for (int i = 0; i <= limit; i++) begin
            if (i > 0) @(negedge usb_clkin);
            if (lat_a < 0 && (bus_a.setup_valid || bus_a.setup_err)) begin
                lat_a = i;
                out_a = bus_a.setup_valid ? OUT_VALID : int'(bus_a.setup_err_code);
                fld_a = {bus_a.w_length, bus_a.w_index, bus_a.w_value, bus_a.b_request, bus_a.bm_request_type};
            end
            if (lat_b < 0 && (bus_b.setup_valid || bus_b.setup_err)) begin
                lat_b = i;
                out_b = bus_b.setup_valid ? OUT_VALID : int'(bus_b.setup_err_code);
                fld_b = {bus_b.w_length, bus_b.w_index, bus_b.w_value, bus_b.b_request, bus_b.bm_request_type};
            end
            if (lat_a >= 0 && lat_b >= 0) break;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        nrst = 1'b0; dev_addr = 7'd0; token_0 = '0; token_0_strb = 1'b0; data_o_0 = '0;
        data_o_strb_0 = 1'b0; data_o_end_0 = 1'b0; data_o_fail_0 = 1'b0; pid_o = 8'h00;
        idle(3);
        n_checks++; if ({bus_a.setup_valid, bus_a.setup_err} !== 2'b00) begin n_errors++;
            $display("FAIL reset_pulses got %b want 00", {bus_a.setup_valid, bus_a.setup_err}); end
        n_checks++; if (bus_a.setup_err_code !== 3'd0) begin n_errors++;
            $display("FAIL reset_code got %0d want 0", bus_a.setup_err_code); end
        n_checks++; if ({bus_a.busy, bus_b.busy} !== 2'b00) begin n_errors++;
            $display("FAIL reset_busy got %b want 00", {bus_a.busy, bus_b.busy}); end
        n_checks++; if ({bus_a.w_length, bus_a.w_index, bus_a.w_value, bus_a.b_request, bus_a.bm_request_type} !== 64'h0) begin
            n_errors++; $display("FAIL reset_fields got nonzero want 0"); end
        nrst = 1'b1;
        exp_f_a = '0; exp_f_b = '0;
        idle(2);
    endtask

    task automatic test_basic();
        logic [7:0] pkt[$];
        pkt = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
        dev_addr = 7'd0;
        token_0 = 24'h10002D; token_0_strb = 1'b1;
        @(negedge usb_clkin);
        token_0_strb = 1'b0;
        n_checks++; if (bus_a.busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy got %b want 1", bus_a.busy); end
        send_packet(pkt, 8'hC3, TERM_END);
        wait_outcome(8);
        n_checks++; if (lat_a !== 1) begin n_errors++; $display("FAIL basic_latency got %0d want 1", lat_a); end
        n_checks++; if (out_a !== OUT_VALID) begin n_errors++; $display("FAIL basic_outcome got %0d want %0d", out_a, OUT_VALID); end
        n_checks++; if (bus_a.bm_request_type !== 8'h80) begin n_errors++; $display("FAIL basic_bm_request_type got %h want 80", bus_a.bm_request_type); end
        n_checks++; if (bus_a.b_request !== 8'h06) begin n_errors++; $display("FAIL basic_b_request got %h want 06", bus_a.b_request); end
        n_checks++; if (bus_a.w_value !== 16'h0100) begin n_errors++; $display("FAIL basic_w_value got %h want 0100", bus_a.w_value); end
        n_checks++; if (bus_a.w_index !== 16'h0000) begin n_errors++; $display("FAIL basic_w_index got %h want 0000", bus_a.w_index); end
        n_checks++; if (bus_a.w_length !== 16'h0040) begin n_errors++; $display("FAIL basic_w_length got %h want 0040", bus_a.w_length); end
        n_checks++; if (out_b !== OUT_VALID || lat_b !== 1) begin n_errors++; $display("FAIL basic_nocrc got %0d/%0d want %0d/1", out_b, lat_b, OUT_VALID); end
        @(negedge usb_clkin);
        n_checks++; if ({bus_a.setup_valid, bus_a.setup_err, bus_a.busy} !== 3'b000) begin n_errors++;
            $display("FAIL basic_pulse_width got %b want 000", {bus_a.setup_valid, bus_a.setup_err, bus_a.busy}); end
        exp_f_a = pkt_fields(pkt); exp_f_b = exp_f_a;
    endtask

    task automatic test_crc_error();
        logic [7:0] pkt[$];
        pkt = '{8'h80, 8'h06, 8'h00, 8'h02, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h95};
        send_token(7'd0, 4'd0, 8'h2D);
        send_packet(pkt, 8'hC3, TERM_END);
        wait_outcome(8);
        n_checks++; if (out_a !== 3 || lat_a !== 1) begin n_errors++; $display("FAIL crc_err got %0d/%0d want 3/1", out_a, lat_a); end
        n_checks++; if (fld_a !== exp_f_a) begin n_errors++; $display("FAIL crc_fields_held got %h want %h", fld_a, exp_f_a); end
        n_checks++; if (out_b !== OUT_VALID || fld_b !== pkt_fields(pkt)) begin n_errors++;
            $display("FAIL crc_unchecked got %0d %h want %0d %h", out_b, fld_b, OUT_VALID, pkt_fields(pkt)); end
        exp_f_b = pkt_fields(pkt);
        idle(2);
    endtask

    task automatic test_ignore_and_pid();
        logic [7:0] pkt[$];
        bit seen_busy;
        seen_busy = 1'b0;
        send_token(7'h05, 4'd0, 8'h2D);
        for (int i = 0; i < 4; i++) begin
            seen_busy |= bus_a.busy | bus_b.busy;
            @(negedge usb_clkin);
        end
        n_checks++; if (seen_busy !== 1'b0) begin n_errors++; $display("FAIL ignore_busy got 1 want 0"); end
        pkt = '{8'h80};
        send_token(7'd0, 4'd0, 8'h2D);
        send_packet(pkt, 8'h4B, TERM_NONE);
        wait_outcome(4);
        n_checks++; if (out_a !== 1 || lat_a !== 0) begin n_errors++; $display("FAIL pid_err got %0d/%0d want 1/0", out_a, lat_a); end
        n_checks++; if (bus_a.busy !== 1'b0) begin n_errors++; $display("FAIL pid_busy got %b want 0", bus_a.busy); end
        idle(2);
    endtask

    task automatic test_length_and_fail();
        logic [7:0] pkt[$];
        int lens[3] = '{9, 11, 26};
        foreach (lens[k]) begin
            build_good(pkt);
            while (pkt.size() > lens[k]) void'(pkt.pop_back());
            while (pkt.size() < lens[k]) pkt.push_back(8'($urandom));
            send_token(7'd0, 4'd0, 8'h2D);
            send_packet(pkt, 8'hC3, TERM_END);
            wait_outcome(8);
            n_checks++; if (out_a !== 2 || out_b !== 2 || lat_a !== 1) begin n_errors++;
                $display("FAIL length_%0d got %0d/%0d lat %0d want 2/2 lat 1", lens[k], out_a, out_b, lat_a); end
            idle(1);
        end
        build_good(pkt);
        while (pkt.size() > 4) void'(pkt.pop_back());
        send_token(7'd0, 4'd0, 8'h2D);
        send_packet(pkt, 8'hC3, TERM_FAIL);
        wait_outcome(4);
        n_checks++; if (out_a !== 4 || lat_a !== 0) begin n_errors++; $display("FAIL fail_err got %0d/%0d want 4/0", out_a, lat_a); end
        build_good(pkt);
        send_token(7'd0, 4'd0, 8'h2D);
        send_packet(pkt, 8'hC3, TERM_FAIL_END);
        wait_outcome(4);
        n_checks++; if (out_a !== 4 || out_b !== 4) begin n_errors++; $display("FAIL fail_beats_end got %0d/%0d want 4/4", out_a, out_b); end
        n_checks++; if (fld_a !== exp_f_a) begin n_errors++; $display("FAIL fail_fields_held got %h want %h", fld_a, exp_f_a); end
        idle(2);
    endtask

    task automatic test_timeout();
        send_token(7'd0, 4'd0, 8'h2D);
        wait_outcome(TIMEOUT + 8);
        n_checks++; if (out_a !== 5 || lat_a !== TIMEOUT) begin n_errors++;
            $display("FAIL timeout got %0d at %0d want 5 at %0d", out_a, lat_a, TIMEOUT); end
        n_checks++; if (bus_a.busy !== 1'b0) begin n_errors++; $display("FAIL timeout_busy got %b want 0", bus_a.busy); end
        idle(2);
    endtask

    task automatic test_preempt();
        logic [7:0] pkt[$];
        build_good(pkt);
        dev_addr = 7'h2A;
        send_token(7'h2A, 4'd0, 8'h2D);
        send_packet(pkt[0:2], 8'hC3, TERM_NONE);
        send_token(7'h2A, 4'd0, 8'h2D);
        wait_outcome(4);
        n_checks++; if (out_a !== 6 || lat_a !== 0 || out_b !== 6) begin n_errors++;
            $display("FAIL preempt got %0d/%0d lat %0d want 6/6 lat 0", out_a, out_b, lat_a); end
        n_checks++; if (bus_a.busy !== 1'b1) begin n_errors++; $display("FAIL preempt_busy got %b want 1", bus_a.busy); end
        build_good(pkt);
        send_packet(pkt, 8'hC3, TERM_END);
        wait_outcome(8);
        n_checks++; if (out_a !== OUT_VALID || fld_a !== pkt_fields(pkt)) begin n_errors++;
            $display("FAIL preempt_second got %0d %h want %0d %h", out_a, fld_a, OUT_VALID, pkt_fields(pkt)); end
        exp_f_a = pkt_fields(pkt); exp_f_b = exp_f_a;
        idle(2);
    endtask

    task automatic test_random();
        logic [7:0] pkt[$];
        logic [7:0] pid;
        logic [6:0] dev;
        int kind, term, ea, eb, v;
        for (int it = 0; it < 30; it++) begin
            dev = 7'($urandom);
            dev_addr = dev;
            @(negedge usb_clkin);
            if ($urandom_range(1, 0) == 1) begin
                v = $urandom_range(2, 0);
                if (v == 0)      send_token(dev + 7'd1, 4'd0, 8'h2D);
                else if (v == 1) send_token(dev, 4'($urandom_range(15, 1)), 8'h2D);
                else             send_token(dev, 4'd0, 8'h69);
                n_checks++; if ({bus_a.busy, bus_b.busy} !== 2'b00) begin n_errors++;
                    $display("FAIL rand%0d_nonmatch_busy got %b want 00", it, {bus_a.busy, bus_b.busy}); end
            end
            kind = $urandom_range(5, 0);
            build_good(pkt);
            pid = 8'hC3;
            term = $urandom_range(1, 0) == 1 ? TERM_END_LAST : TERM_END;
            case (kind)
                1: pkt[$urandom_range(9, 0)] ^= 8'(1 << $urandom_range(7, 0));
                2: repeat ($urandom_range(9, 1)) void'(pkt.pop_back());
                3: repeat ($urandom_range(7, 1)) pkt.push_back(8'($urandom));
                4: begin
                    repeat ($urandom_range(9, 0)) void'(pkt.pop_back());
                    term = $urandom_range(1, 0) == 1 ? TERM_FAIL : TERM_FAIL_END;
                end
                5: begin
                    pid = 8'h4B;
                    while (pkt.size() > 1) void'(pkt.pop_back());
                    term = TERM_NONE;
                end
                default: ;
            endcase
            ea = predict(pkt, pid, kind == 4, 1'b1);
            eb = predict(pkt, pid, kind == 4, 1'b0);
            if (ea == OUT_VALID) exp_f_a = pkt_fields(pkt);
            if (eb == OUT_VALID) exp_f_b = pkt_fields(pkt);
            send_token(dev, 4'd0, 8'h2D);
            send_packet(pkt, pid, term);
            wait_outcome(8);
            n_checks++; if (out_a !== ea || lat_a !== exp_latency(ea)) begin n_errors++;
                $display("FAIL rand%0d_a kind %0d got %0d lat %0d want %0d lat %0d", it, kind, out_a, lat_a, ea, exp_latency(ea)); end
            n_checks++; if (out_b !== eb || lat_b !== exp_latency(eb)) begin n_errors++;
                $display("FAIL rand%0d_b kind %0d got %0d lat %0d want %0d lat %0d", it, kind, out_b, lat_b, eb, exp_latency(eb)); end
            n_checks++; if (fld_a !== exp_f_a || fld_b !== exp_f_b) begin n_errors++;
                $display("FAIL rand%0d_fields got %h %h want %h %h", it, fld_a, fld_b, exp_f_a, exp_f_b); end
            idle($urandom_range(2, 1));
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] pkt[$];
        build_good(pkt);
        dev_addr = 7'd0;
        send_token(7'd0, 4'd0, 8'h2D);
        send_packet(pkt[0:4], 8'hC3, TERM_NONE);
        #2 nrst = 1'b0;
        #1;
        n_checks++; if ({bus_a.busy, bus_b.busy, bus_a.setup_err_code} !== 5'b0) begin n_errors++;
            $display("FAIL midreset_state got %b want 0", {bus_a.busy, bus_b.busy, bus_a.setup_err_code}); end
        n_checks++; if ({bus_a.w_length, bus_a.w_index, bus_a.w_value, bus_a.b_request, bus_a.bm_request_type} !== 64'h0) begin
            n_errors++; $display("FAIL midreset_fields got nonzero want 0"); end
        @(negedge usb_clkin);
        nrst = 1'b1;
        exp_f_a = '0; exp_f_b = '0;
        @(negedge usb_clkin);
        pkt = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
        send_token(7'd0, 4'd0, 8'h2D);
        send_packet(pkt, 8'hC3, TERM_END);
        wait_outcome(8);
        n_checks++; if (out_a !== OUT_VALID || fld_a !== 64'h0040_0000_0100_0680) begin n_errors++;
            $display("FAIL midreset_recover got %0d %h want %0d 0040000001000680", out_a, fld_a, OUT_VALID); end
        idle(2);
    endtask

    task automatic test_exclusive();
        n_checks++; if (both_high !== 1'b0) begin n_errors++; $display("FAIL exclusive_pulses got 1 want 0"); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_crc_error();
        test_ignore_and_pid();
        test_length_and_fail();
        test_timeout();
        test_preempt();
        test_random();
        test_reset_mid();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
